act_lut_loader: RTL and testbench
=================================

ACT_LUT_LOADER -- requirements
Module: act_lut_loader

Interface
REQ-001 SHALL have parameter DATA_W, default 8, meaning signed table entry width.
REQ-002 SHALL have parameter ADDR_W, default 4, meaning segment address width; the table holds 2**ADDR_W+1 entries (17 by default).
REQ-003 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst, input, 1, the reset: synchronous and active-high.
REQ-005 SHALL have port start, input, 1, a one-cycle pulse that begins a table load.
REQ-006 SHALL have port wr_valid, input, 1, meaning a write word is offered.
REQ-007 SHALL have port wr_data, input, DATA_W, the signed write word.
REQ-008 SHALL have port wr_ready, output, 1, meaning the block accepts a write word this cycle.
REQ-009 SHALL have port rd_en, input, 1, the read request.
REQ-010 SHALL have port address, input, ADDR_W, the segment index to read.
REQ-011 SHALL have port base, output, DATA_W, the registered entry at tbl[address].
REQ-012 SHALL have port next_data, output, DATA_W, the registered entry at tbl[address+1].
REQ-013 SHALL have port rd_valid, output, 1, meaning base and next_data are valid this cycle.
REQ-014 SHALL have port table_ok, output, 1, meaning the table is fully loaded and usable.
REQ-015 SHALL have port busy, output, 1, high in LOAD or CHECK.
REQ-016 SHALL have port error, output, 1, meaning a sticky checksum failure.

Function
REQ-017 SHALL implement FSM states IDLE, LOAD, CHECK, READY and FAIL.
REQ-018 SHALL, on start in any state, enter LOAD, clear the entry counter to 0 and deassert table_ok and error; a start pulse during LOAD restarts from entry 0.
REQ-019 SHALL assert wr_ready only in LOAD and CHECK; a write word transfers on a cycle with wr_valid=1 and wr_ready=1.
REQ-020 SHALL, in LOAD, write each transferred word to tbl[count] and increment count; the transfer at count=2**ADDR_W is the last.
REQ-021 SHALL, after the last transfer, go to CHECK when ACT_LUT_CHECKSUM_EN is defined, otherwise to READY.
REQ-022 SHALL give start priority over a simultaneous write handshake; that word is dropped.
REQ-023 SHALL hold table_ok=1 only in READY; the cycle after the last LOAD transfer (or the CHECK pass) SHALL show table_ok=1.
REQ-024 SHALL, on rd_en=1 in READY, register tbl[address] and tbl[address+1] to base and next_data, with rd_valid=1 one cycle later (read latency 1).
REQ-025 SHALL, on rd_en outside READY, set rd_valid=0 and base=next_data=0 the next cycle; rd_valid=0 on any cycle with no rd_en.
REQ-026 SHALL have address=2**ADDR_W-1 return tbl[15] and tbl[16]; the address never wraps.
REQ-027 SHALL leave table contents untouched in IDLE, READY and FAIL.

Reset
REQ-028 SHALL, on rst, enter IDLE with count=0, checksum=0, table_ok=0, busy=0, error=0, wr_ready=0, rd_valid=0, base=0 and next_data=0; rst overrides start.
REQ-029 SHALL not clear table storage on reset, and SHALL hold table_ok=0 until a complete reload.
REQ-030 SHALL, on rst during LOAD, abandon the load; a later start reloads from entry 0.

Configuration
REQ-031 SHALL, with ACT_LUT_CHECKSUM_EN defined, keep an 8-bit modulo-256 sum of the LOAD words, accept one extra word in CHECK, go to READY on equality and to FAIL (error=1, sticky until start or rst) otherwise.
REQ-032 SHALL, without ACT_LUT_CHECKSUM_EN, have no CHECK state, no checksum register and error tied to 0.

Verification
REQ-033 SHALL cover: rst, then start, then 17 words 0..16 with wr_valid held high -> table_ok=1 the cycle after word 16, busy=0, and rd_en with address=3 -> next cycle base=3, next_data=4, rd_valid=1.
REQ-034 SHALL cover: words with wr_valid toggled every other cycle -> only handshake cycles write, and readback matches for all 16 addresses.
REQ-035 SHALL cover: start after 9 words, then 17 words of 0x7F..0x6F -> address=0 reads base=0x7F and next_data=0x7E.
REQ-036 SHALL cover: rd_en before any load -> rd_valid=0 and base=0; address=15 after a load of values -8..8 -> base=7, next_data=8.
REQ-037 SHALL cover, with ACT_LUT_CHECKSUM_EN: checksum 0x88 for words 0..16 -> READY; checksum 0x00 -> error=1, table_ok=0 until the next start.
REQ-038 SHALL cover: rst asserted with start in the same cycle mid-LOAD -> IDLE, table_ok=0, wr_ready=0 the next cycle.

Source files
------------

// File: rtl/act_lut_loader.sv
// Activation LUT loader: streams 2**ADDR_W+1 signed entries into a table and then serves segment reads.
// Latency: a read returns tbl[address] and tbl[address+1] one cycle after rd_en; table_ok rises the cycle after the final word.
// Backpressure: wr_ready is high only while loading (or checking); reads outside READY return zeros with rd_valid low.
// Optional: define ACT_LUT_CHECKSUM_EN to require a trailing modulo-256 checksum word after the table words.
module act_lut_loader #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              wr_valid,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_ready,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] address,
  output logic [DATA_W-1:0] base,
  output logic [DATA_W-1:0] next_data,
  output logic              rd_valid,
  output logic              table_ok,
  output logic              busy,
  output logic              error
);

  localparam int DEPTH = (1 << ADDR_W) + 1;
  // Index of the final table entry; the transfer landing here ends the load.
  localparam logic [ADDR_W:0] LAST = {1'b1, {ADDR_W{1'b0}}};

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
`ifdef ACT_LUT_CHECKSUM_EN
    S_CHECK,
`endif
    S_READY,
    S_FAIL
  } state_t;

  state_t            state;
  logic [ADDR_W:0]   count;
  logic [DATA_W-1:0] tbl [DEPTH];

  logic              wr_fire;
  logic              load_wr;
  logic [ADDR_W:0]   rd_idx;
  logic [ADDR_W:0]   rd_idx_n;

  assign wr_fire  = wr_valid & wr_ready;
  // start wins over a coincident handshake, so that word never reaches the table.
  assign load_wr  = (state == S_LOAD) && wr_fire && !start && !rst;
  assign rd_idx   = {1'b0, address};
  assign rd_idx_n = rd_idx + (ADDR_W+1)'(1);

`ifdef ACT_LUT_CHECKSUM_EN
  logic [7:0] csum;
  logic [7:0] wr_byte;
  // Checksum is taken over the sign-extended word, truncated to 8 bits.
  assign wr_byte = 8'(signed'(wr_data));
`else
  assign error = 1'b0;
`endif

  // Table storage: written only by accepted LOAD words, never reset.
  always_ff @(posedge clk) begin
    if (load_wr) begin
      tbl[count] <= wr_data;
    end
  end

  // Control FSM with registered status outputs; rst beats start, start beats everything else.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      count    <= '0;
      table_ok <= 1'b0;
      busy     <= 1'b0;
      wr_ready <= 1'b0;
`ifdef ACT_LUT_CHECKSUM_EN
      csum     <= '0;
      error    <= 1'b0;
`endif
    end else if (start) begin
      state    <= S_LOAD;
      count    <= '0;
      table_ok <= 1'b0;
      busy     <= 1'b1;
      wr_ready <= 1'b1;
`ifdef ACT_LUT_CHECKSUM_EN
      csum     <= '0;
      error    <= 1'b0;
`endif
    end else begin
      case (state)
        S_LOAD: begin
          if (wr_fire) begin
            count <= count + (ADDR_W+1)'(1);
`ifdef ACT_LUT_CHECKSUM_EN
            csum  <= csum + wr_byte;
`endif
            if (count == LAST) begin
`ifdef ACT_LUT_CHECKSUM_EN
              state    <= S_CHECK;
`else
              state    <= S_READY;
              table_ok <= 1'b1;
              busy     <= 1'b0;
              wr_ready <= 1'b0;
`endif
            end
          end
        end
`ifdef ACT_LUT_CHECKSUM_EN
        S_CHECK: begin
          if (wr_fire) begin
            busy     <= 1'b0;
            wr_ready <= 1'b0;
            if (wr_byte == csum) begin
              state    <= S_READY;
              table_ok <= 1'b1;
            end else begin
              state <= S_FAIL;
              error <= 1'b1;
            end
          end
        end
`endif
        default: begin
          // IDLE, READY and FAIL hold until start or rst.
        end
      endcase
    end
  end

  // Read port: one-cycle registered lookup of a segment's two endpoints.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_valid  <= 1'b0;
      base      <= '0;
      next_data <= '0;
    end else if (rd_en) begin
      if (state == S_READY) begin
        rd_valid  <= 1'b1;
        base      <= tbl[rd_idx];
        next_data <= tbl[rd_idx_n];
      end else begin
        rd_valid  <= 1'b0;
        base      <= '0;
        next_data <= '0;
      end
    end else begin
      rd_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_act_lut_loader.sv
module tb_act_lut_loader;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic       wr_valid = 1'b0;
  logic [7:0] wr_data = '0;
  logic       wr_ready;
  logic       rd_en = 1'b0;
  logic [3:0] address = '0;
  logic [7:0] base;
  logic [7:0] next_data;
  logic       rd_valid;
  logic       table_ok;
  logic       busy;
  logic       error;

  int tests = 0;
  int fails = 0;

  act_lut_loader #(.DATA_W(8), .ADDR_W(4)) dut (
    .clk(clk), .rst(rst), .start(start),
    .wr_valid(wr_valid), .wr_data(wr_data), .wr_ready(wr_ready),
    .rd_en(rd_en), .address(address),
    .base(base), .next_data(next_data), .rd_valid(rd_valid),
    .table_ok(table_ok), .busy(busy), .error(error)
  );

  always #5 clk = ~clk;

  // Inputs change at the falling edge; outputs are checked at the next falling edge.
  task automatic tick();
    @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [7:0] d);
    wr_valid = 1'b1;
    wr_data  = d;
    tick();
    wr_valid = 1'b0;
  endtask

  task automatic read(input logic [3:0] a);
    rd_en   = 1'b1;
    address = a;
    tick();
    rd_en   = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Closes a load after the 17th word: supplies the checksum word when that feature is built in.
  task automatic finish_load(input string tag, input logic [7:0] csum);
`ifdef ACT_LUT_CHECKSUM_EN
    check({tag, "_check_busy"}, busy, 1);
    check({tag, "_check_ok_low"}, table_ok, 0);
    send(csum);
`endif
    check({tag, "_table_ok"}, table_ok, 1);
    check({tag, "_busy_low"}, busy, 0);
    check({tag, "_wr_ready_low"}, wr_ready, 0);
    check({tag, "_error_low"}, error, 0);
  endtask

  initial begin
    // Reset with start also high: reset must win.
    rst = 1'b1; start = 1'b1;
    tick(); tick();
    start = 1'b0;
    tick();
    rst = 1'b0;
    tick();
    check("rst_table_ok", table_ok, 0);
    check("rst_busy", busy, 0);
    check("rst_error", error, 0);
    check("rst_wr_ready", wr_ready, 0);
    check("rst_rd_valid", rd_valid, 0);
    check("rst_base", base, 0);
    check("rst_next", next_data, 0);

    // Read before any load.
    read(4'd0);
    check("preload_rd_valid", rd_valid, 0);
    check("preload_base", base, 0);

    // Load 0..16 with wr_valid held high.
    pulse_start();
    check("load1_busy", busy, 1);
    check("load1_wr_ready", wr_ready, 1);
    check("load1_ok_low", table_ok, 0);
    for (int i = 0; i < 17; i++) begin
      send(8'(i));
      if (i == 15) check("load1_ok_before_last", table_ok, 0);
    end
    finish_load("load1", 8'h88);
    read(4'd3);
    check("load1_base3", base, 8'h03);
    check("load1_next3", next_data, 8'h04);
    check("load1_rd_valid", rd_valid, 1);
    tick();
    check("load1_rd_valid_drop", rd_valid, 0);

`ifdef ACT_LUT_CHECKSUM_EN
    // Wrong checksum: error sticks and table_ok stays low until the next start.
    pulse_start();
    for (int i = 0; i < 17; i++) send(8'(i));
    send(8'h00);
    check("csum_bad_error", error, 1);
    check("csum_bad_ok", table_ok, 0);
    check("csum_bad_busy", busy, 0);
    tick();
    check("csum_bad_error_sticky", error, 1);
    read(4'd3);
    check("csum_bad_rd_valid", rd_valid, 0);
    pulse_start();
    check("csum_bad_error_cleared", error, 0);
`else
    pulse_start();
`endif

    // Toggled wr_valid: idle cycles carry a poison value that must not be written.
    for (int i = 0; i < 17; i++) begin
      send(8'(100 - i));
      wr_data = 8'hEE;
      tick();
      if (i == 8) check("toggle_ok_mid", table_ok, 0);
    end
    finish_load("toggle", 8'h1C);
    for (int a = 0; a < 16; a++) begin
      read(4'(a));
      check($sformatf("toggle_base%0d", a), base, 32'(8'(100 - a)));
      check($sformatf("toggle_next%0d", a), next_data, 32'(8'(99 - a)));
    end

    // Restart after 9 words; the word offered with the restart is dropped.
    pulse_start();
    for (int i = 0; i < 9; i++) send(8'h55);
    check("restart_ok_low", table_ok, 0);
    read(4'd2);
    check("rd_in_load_valid", rd_valid, 0);
    check("rd_in_load_base", base, 0);
    start = 1'b1;
    send(8'h33);
    start = 1'b0;
    for (int i = 0; i < 17; i++) send(8'(8'h7F - i));
    finish_load("restart", 8'hE7);
    read(4'd0);
    check("restart_base0", base, 8'h7F);
    check("restart_next0", next_data, 8'h7E);
    read(4'd15);
    check("restart_base15", base, 8'h70);
    check("restart_next15", next_data, 8'h6F);

    // Signed values -8..8; top address reads the last two entries.
    pulse_start();
    for (int i = 0; i < 17; i++) send(8'(i - 8));
    finish_load("signed", 8'h00);
    read(4'd15);
    check("signed_base15", base, 8'h07);
    check("signed_next15", next_data, 8'h08);
    read(4'd0);
    check("signed_base0", base, 8'hF8);
    check("signed_next0", next_data, 8'hF9);

    // rst together with start mid-load.
    pulse_start();
    for (int i = 0; i < 5; i++) send(8'(i + 40));
    rst = 1'b1; start = 1'b1;
    tick();
    rst = 1'b0; start = 1'b0;
    check("midrst_ok", table_ok, 0);
    check("midrst_wr_ready", wr_ready, 0);
    check("midrst_busy", busy, 0);
    tick();
    check("midrst_idle_wr_ready", wr_ready, 0);
    read(4'd1);
    check("midrst_rd_valid", rd_valid, 0);
    pulse_start();
    for (int i = 0; i < 17; i++) send(8'(i));
    finish_load("reload", 8'h88);
    read(4'd8);
    check("reload_base8", base, 8'h08);
    check("reload_next8", next_data, 8'h09);
    check("reload_rd_valid", rd_valid, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
